// File: rtl/pipeline_controller_pkg.sv
// ==== common : shared types for pipeline_controller -- rev 1.0 ====
`default_nettype none

package common;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_out_t;

  localparam ctrl_out_t C_CTRL_IDLE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b0
  };

  localparam ctrl_out_t C_CTRL_DEFAULT = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_write: 1'b1,
    id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
  };

  localparam ctrl_out_t C_CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
    id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1
  };

  localparam ctrl_out_t C_CTRL_FLUSH = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_write: 1'b1,
    id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
  };

  localparam ctrl_out_t C_CTRL_STALL = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b1,
    id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
  };

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_if.sv
// ==== pipeline_controller_if : hazard requests, stage controls, counters -- rev 1.0 ====
`default_nettype none

interface pipeline_controller_if #(
  parameter int CNT_W = 16
);

  logic             load_use;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_write;
  logic             mem_wb_bubble;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output load_use, branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_error, stall_cycles, flush_events
  );

  modport slave (
    input  load_use, branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, mem_wb_bubble, mem_error, stall_cycles, flush_events
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_controller_sat_counter.sv
// ==== sat_counter : up-counter that holds at all-ones -- rev 1.0 ====
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         inc,
  output logic      [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// ==== pipeline_controller : stall/flush/freeze control for a 5-stage pipeline -- rev 1.0 ====
`default_nettype none

module pipeline_controller
  import common::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  wire logic           clk,
  input  wire logic           reset,
  pipeline_controller_if.slave bus
);

  localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_error;
  logic              w_timeout;
  logic              w_freeze;
  ctrl_out_t         w_ctrl;

  // The wait count covers every frozen cycle of one access, including the RUN cycle that starts it.
  always_comb begin
    w_timeout = (r_state == MEM_WAIT) && !bus.dmem_ready && (r_wait_cnt >= C_WAIT_LAST);
    if (r_state == RUN) begin
      w_freeze = bus.dmem_req && !bus.dmem_ready;
    end else begin
      w_freeze = !bus.dmem_ready && !w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_freeze) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_freeze)  w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (!w_freeze) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  // Branch and load-use requests are only honoured in RUN; MEM_WAIT releases with plain defaults.
  always_comb begin
    w_ctrl = C_CTRL_DEFAULT;
    if (reset) begin
      w_ctrl = C_CTRL_IDLE;
    end else if (w_freeze) begin
      w_ctrl = C_CTRL_FREEZE;
    end else if ((r_state == RUN) && bus.branch_taken) begin
      w_ctrl = C_CTRL_FLUSH;
    end else if ((r_state == RUN) && bus.load_use) begin
      w_ctrl = C_CTRL_STALL;
    end
  end

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.if_id_write   = w_ctrl.if_id_write;
  assign bus.if_id_flush   = w_ctrl.if_id_flush;
  assign bus.id_ex_write   = w_ctrl.id_ex_write;
  assign bus.id_ex_bubble  = w_ctrl.id_ex_bubble;
  assign bus.ex_mem_write  = w_ctrl.ex_mem_write;
  assign bus.mem_wb_bubble = w_ctrl.mem_wb_bubble;
  assign bus.mem_error     = r_mem_error;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!w_ctrl.pc_write),
    .count (bus.stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_ctrl.if_id_flush),
    .count (bus.flush_events)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// ==== tb_pipeline_controller : two parameterisations checked against a reference model -- rev 1.0 ====
`default_nettype none

module tb_pipeline_controller;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
  localparam logic [6:0] E_IDLE   = 7'b0000000;
  localparam logic [6:0] E_DEF    = 7'b1101010;
  localparam logic [6:0] E_FREEZE = 7'b0000001;
  localparam logic [6:0] E_FLUSH  = 7'b1111110;
  localparam logic [6:0] E_STALL  = 7'b0001110;

  logic clk = 1'b0;
  logic reset, load_use, branch_taken, dmem_req, dmem_ready;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_controller_if #(.CNT_W(16)) bus_a ();
  pipeline_controller_if #(.CNT_W(2))  bus_b ();

  assign bus_a.load_use = load_use;   assign bus_b.load_use = load_use;
  assign bus_a.branch_taken = branch_taken; assign bus_b.branch_taken = branch_taken;
  assign bus_a.dmem_req = dmem_req;   assign bus_b.dmem_req = dmem_req;
  assign bus_a.dmem_ready = dmem_ready; assign bus_b.dmem_ready = dmem_ready;

  pipeline_controller #(.MEM_TIMEOUT(255), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  pipeline_controller #(.MEM_TIMEOUT(4),   .CNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Reference model: per DUT, whether an access is outstanding and how many freeze cycles it has used.
  int tmo  [2] = '{255, 4};
  int cmax [2] = '{65535, 3};
  bit m_pending [2];
  int m_nfrz    [2];
  int m_stall   [2];
  int m_flush   [2];
  bit m_err     [2];
  bit m_valid = 1'b0;

  function automatic logic [6:0] model_ctrl(int k);
    bit outstanding;
    if (reset) return E_IDLE;
    outstanding = m_pending[k] || dmem_req;
    if (outstanding && !dmem_ready && (m_nfrz[k] < tmo[k] - 1)) return E_FREEZE;
    if (m_pending[k]) return E_DEF;
    if (branch_taken) return E_FLUSH;
    if (load_use) return E_STALL;
    return E_DEF;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int k, logic [6:0] ctrl, logic err, logic [15:0] sc, logic [15:0] fe);
    string s;
    s = (k == 0) ? "a" : "b";
    check({"ctrl_", s}, 32'(ctrl), 32'(model_ctrl(k)));
    if (m_valid) begin
      check({"mem_error_", s},    32'(err), 32'(m_err[k]));
      check({"stall_cycles_", s}, 32'(sc),  32'(m_stall[k]));
      check({"flush_events_", s}, 32'(fe),  32'(m_flush[k]));
    end
  endtask

  task automatic step(bit r, bit lu, bit br, bit rq, bit rd);
    logic [6:0] e [2];
    reset = r; load_use = lu; branch_taken = br; dmem_req = rq; dmem_ready = rd;
    #1;
    check_dut(0, {bus_a.pc_write, bus_a.if_id_write, bus_a.if_id_flush, bus_a.id_ex_write,
                  bus_a.id_ex_bubble, bus_a.ex_mem_write, bus_a.mem_wb_bubble},
              bus_a.mem_error, bus_a.stall_cycles, bus_a.flush_events);
    check_dut(1, {bus_b.pc_write, bus_b.if_id_write, bus_b.if_id_flush, bus_b.id_ex_write,
                  bus_b.id_ex_bubble, bus_b.ex_mem_write, bus_b.mem_wb_bubble},
              bus_b.mem_error, 16'(bus_b.stall_cycles), 16'(bus_b.flush_events));
    for (int k = 0; k < 2; k++) e[k] = model_ctrl(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_pending[k] = 1'b0; m_nfrz[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_err[k] = 1'b0;
      end else begin
        if (!e[k][6] && m_stall[k] < cmax[k]) m_stall[k]++;
        if (e[k][4] && m_flush[k] < cmax[k]) m_flush[k]++;
        if (m_pending[k] && !rd && (m_nfrz[k] >= tmo[k] - 1)) m_err[k] = 1'b1;
        if (e[k] == E_FREEZE) begin
          m_pending[k] = 1'b1; m_nfrz[k]++;
        end else begin
          m_pending[k] = 1'b0; m_nfrz[k] = 0;
        end
      end
    end
    if (r) m_valid = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load_use = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Single load-use stall, then branch with a simultaneous load-use.
    step(0, 1, 0, 0, 0);
    check("stall_after_load_use", 32'(bus_a.stall_cycles), 32'd1);
    step(0, 1, 1, 0, 0);
    check("flush_after_branch", 32'(bus_a.flush_events), 32'd1);
    check("stall_unchanged_on_branch", 32'(bus_a.stall_cycles), 32'd1);

    // Memory wait of three cycles with branch held high, released on the fourth.
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    check("stall_after_mem_wait", 32'(bus_a.stall_cycles), 32'd3);
    check("no_flush_while_frozen", 32'(bus_a.flush_events), 32'd0);
    step(0, 0, 1, 0, 0);
    check("flush_once_back_in_run", 32'(bus_a.flush_events), 32'd1);

    // Timeout on the MEM_TIMEOUT=4 instance only.
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    check("mem_error_after_timeout_b", 32'(bus_b.mem_error), 32'd1);
    check("no_mem_error_a", 32'(bus_a.mem_error), 32'd0);
    check("stall_at_timeout_b", 32'(bus_b.stall_cycles), 32'd3);
    step(0, 0, 0, 0, 0);

    // Reset in the middle of a wait; the branch then proves the state is RUN.
    repeat (2) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("mem_error_cleared_b", 32'(bus_b.mem_error), 32'd0);
    check("stall_cleared_a", 32'(bus_a.stall_cycles), 32'd0);
    step(0, 0, 1, 0, 0);
    check("flush_first_after_reset", 32'(bus_a.flush_events), 32'd1);

    // Saturation of the 2-bit counter.
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    check("stall_saturated_b", 32'(bus_b.stall_cycles), 32'd3);
    check("stall_unsaturated_a", 32'(bus_a.stall_cycles), 32'd5);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), 1'($urandom), 1'($urandom_range(3) == 0),
           1'($urandom), ($urandom_range(2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before the controller forces release.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_use  input  1  load-use hazard request from the hazard detection unit (its bubble output).
REQ-006 branch_taken  input  1  EX-stage branch/jump resolved taken.
REQ-007 dmem_req  input  1  MEM-stage load/store in flight.
REQ-008 dmem_ready  input  1  data memory completes the current access this cycle.
REQ-009 pc_write  output  1  PC register enable.
REQ-010 if_id_write  output  1  IF/ID register enable.
REQ-011 if_id_flush  output  1  IF/ID loads a NOP.
REQ-012 id_ex_write  output  1  ID/EX register enable.
REQ-013 id_ex_bubble  output  1  ID/EX loads a NOP.
REQ-014 ex_mem_write  output  1  EX/MEM register enable.
REQ-015 mem_wb_bubble  output  1  MEM/WB loads a NOP.
REQ-016 mem_error  output  1  sticky flag: a memory access timed out.
REQ-017 stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0.
REQ-018 flush_events  output  CNT_W  saturating count of cycles with if_id_flush=1.

Function
REQ-019 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-020 Control outputs SHALL be combinational from state and inputs (Mealy), with zero latency.
REQ-021 Default values (no hazard) SHALL be: all write enables 1, all flush/bubble outputs 0.
REQ-022 Priority SHALL be: memory freeze > branch flush > load-use stall.
REQ-023 RUN with dmem_req=1 and dmem_ready=0 SHALL freeze the pipeline and go to MEM_WAIT next cycle.
  - Freeze means: pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_bubble=1.
  - Branch and load-use requests are ignored while frozen.
REQ-024 RUN with dmem_req=1 and dmem_ready=1 SHALL NOT stall and SHALL stay in RUN.
REQ-025 MEM_WAIT with dmem_ready=0 SHALL keep the freeze.
REQ-026 MEM_WAIT with dmem_ready=1 SHALL apply default outputs and return to RUN next cycle.
REQ-027 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-028 When the wait counter equals MEM_TIMEOUT-1 and dmem_ready=0, the controller SHALL:
  - set mem_error on the next edge;
  - apply default outputs in that cycle;
  - return to RUN.
REQ-029 Unfrozen cycle with branch_taken=1 SHALL drive if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; load_use is ignored that cycle.
REQ-030 Unfrozen cycle with load_use=1 and branch_taken=0 SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1; id_ex_write and ex_mem_write stay 1.
REQ-031 stall_cycles SHALL increment on each cycle with pc_write=0, saturating at all-ones.
REQ-032 flush_events SHALL increment on each cycle with if_id_flush=1, saturating at all-ones.
REQ-033 mem_error SHALL clear only on reset.

Reset
REQ-034 On reset, the next state SHALL be:
  - state RUN;
  - wait counter 0;
  - stall_cycles and flush_events 0;
  - mem_error 0.
REQ-035 While reset=1, all write enables SHALL be 0, all flush/bubble outputs 0, and counters SHALL NOT increment.
REQ-036 Reset asserted during MEM_WAIT SHALL abandon the wait; the first post-reset cycle is RUN.

Structure
REQ-037 Enum ctrl_state_t {RUN, MEM_WAIT} SHALL live in package common.
REQ-038 The saturating counter SHALL be a sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice.
REQ-039 The wait counter width SHALL be $clog2(MEM_TIMEOUT+1).

Verification
REQ-040 The bench SHALL cover:
  - load_use=1 for one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles 0->1.
  - branch_taken=1 and load_use=1 together -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_events +1, stall_cycles unchanged.
  - dmem_req=1, dmem_ready low 3 cycles then high -> freeze for 3 cycles, release on the 4th cycle; stall_cycles=3; branch_taken held high throughout is not acted on until RUN.
  - MEM_TIMEOUT=4, dmem_ready never asserted -> freeze 3 cycles, release on the 4th, mem_error=1 thereafter, state RUN.
  - reset asserted mid-MEM_WAIT -> next cycle RUN, counters 0, mem_error 0.
  - CNT_W=2 with 5 load-use stalls -> stall_cycles saturates at 3.
